// File: rtl/seven_segment_reader.sv
// Seven-segment display snooper: recovers a hex byte from a two-digit
// multiplexed common-anode display by watching its enable and segment lines.
module seven_segment_reader #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       cmosClock,
  input  logic       resetN,
  input  logic [3:0] sevenSegmentEnable,
  input  logic [7:0] sevenSegmentData,
  output logic [7:0] byteOut,
  output logic       byteValid,
  output logic       byteChanged,
  output logic       glyphError,
  output logic       linkActive
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] HAVE_LO = 1'b1;

  localparam logic [3:0] EN_DIGIT0 = 4'b1110;
  localparam logic [3:0] EN_DIGIT1 = 4'b1101;

  logic [3:0]    enMeta_p0;
  logic [3:0]    enSync_p1;
  logic [3:0]    enPrev_p2;
  logic [7:0]    dataMeta_p0;
  logic [7:0]    dataSync_p1;
  logic [SW-1:0] settleCnt;
  logic [TW-1:0] timeoutCnt;
  logic [0:0]    frameState;
  logic [3:0]    loNibble;

  logic          enChanged;
  logic          isDigit0;
  logic          isDigit1;
  logic          takeSample;
  logic          glyphHit;
  logic [3:0]    sampleNibble;
  logic          validSample;

  // Active-low segment glyph to {hit, nibble}; the decimal point is a don't-care.
  function automatic logic [4:0] decodeGlyph(input logic [7:0] seg);
    logic [4:0] res;
    casez (seg)
      8'b?1000000: res = 5'h10;
      8'b?1111001: res = 5'h11;
      8'b?0100100: res = 5'h12;
      8'b?0110000: res = 5'h13;
      8'b?0011001: res = 5'h14;
      8'b?0010010: res = 5'h15;
      8'b?0000010: res = 5'h16;
      8'b?1111000: res = 5'h17;
      8'b?0000000: res = 5'h18;
      8'b?0010000: res = 5'h19;
      8'b?0001000: res = 5'h1A;
      8'b?0000011: res = 5'h1B;
      8'b?1000110: res = 5'h1C;
      8'b?0100001: res = 5'h1D;
      8'b?0000110: res = 5'h1E;
      8'b?0001110: res = 5'h1F;
      default:     res = 5'h00;
    endcase
    return res;
  endfunction

  // Two-flop synchronizer for both buses, idling at "all segments/digits off".
  always_ff @(posedge cmosClock) begin
    if (!resetN) begin
      enMeta_p0   <= 4'b1111;
      enSync_p1   <= 4'b1111;
      dataMeta_p0 <= 8'hFF;
      dataSync_p1 <= 8'hFF;
    end else begin
      enMeta_p0   <= sevenSegmentEnable;
      enSync_p1   <= enMeta_p0;
      dataMeta_p0 <= sevenSegmentData;
      dataSync_p1 <= dataMeta_p0;
    end
  end

  // Sample decision: one shot per dwell, on the cycle the settle count completes.
  always_comb begin
    enChanged                = (enSync_p1 != enPrev_p2);
    isDigit0                 = (enSync_p1 == EN_DIGIT0);
    isDigit1                 = (enSync_p1 == EN_DIGIT1);
    takeSample               = (isDigit0 || isDigit1) && !enChanged && (settleCnt == SETTLE_LAST);
    {glyphHit, sampleNibble} = decodeGlyph(dataSync_p1);
    validSample              = takeSample && glyphHit;
  end

  // Settle counter: restarts on any enable change, idles on non-digit patterns.
  always_ff @(posedge cmosClock) begin
    if (!resetN) begin
      enPrev_p2 <= 4'b1111;
      settleCnt <= '0;
    end else begin
      enPrev_p2 <= enSync_p1;
      if (enChanged || !(isDigit0 || isDigit1)) begin
        settleCnt <= '0;
      end else if (settleCnt != SETTLE_MAX) begin
        settleCnt <= settleCnt + 1'b1;
      end
    end
  end

  // Frame assembly: low nibble is held until a high nibble completes the byte.
  always_ff @(posedge cmosClock) begin
    if (!resetN) begin
      frameState  <= HUNT;
      loNibble    <= 4'h0;
      byteOut     <= 8'h00;
      byteValid   <= 1'b0;
      byteChanged <= 1'b0;
      glyphError  <= 1'b0;
    end else begin
      byteValid   <= 1'b0;
      byteChanged <= 1'b0;
      glyphError  <= 1'b0;
      if (takeSample) begin
        if (!glyphHit) begin
          glyphError <= 1'b1;
          frameState <= HUNT;
        end else if (isDigit0) begin
          loNibble   <= sampleNibble;
          frameState <= HAVE_LO;
        end else if (frameState == HAVE_LO) begin
          byteOut     <= {sampleNibble, loNibble};
          byteValid   <= 1'b1;
          byteChanged <= ({sampleNibble, loNibble} != byteOut);
          frameState  <= HUNT;
        end
      end
    end
  end

  // Link watchdog: any decodable sample keeps the link alive; bad glyphs do not.
  always_ff @(posedge cmosClock) begin
    if (!resetN) begin
      timeoutCnt <= '0;
      linkActive <= 1'b0;
    end else if (validSample) begin
      timeoutCnt <= '0;
      linkActive <= 1'b1;
    end else if (timeoutCnt != TIMEOUT_MAX) begin
      timeoutCnt <= timeoutCnt + 1'b1;
      if (timeoutCnt == TIMEOUT_LAST) begin
        linkActive <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_seven_segment_reader;

  logic       cmosClock;
  logic       resetN;
  logic [3:0] sevenSegmentEnable;
  logic [7:0] sevenSegmentData;
  logic [7:0] byteOut;
  logic       byteValid;
  logic       byteChanged;
  logic       glyphError;
  logic       linkActive;

  int nVec;
  int nBad;
  int vldCnt;
  int chgCnt;
  int errCnt;
  int vldBase;
  int chgBase;
  int errBase;
  logic gotValid;

  seven_segment_reader #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .cmosClock         (cmosClock),
    .resetN            (resetN),
    .sevenSegmentEnable(sevenSegmentEnable),
    .sevenSegmentData  (sevenSegmentData),
    .byteOut           (byteOut),
    .byteValid         (byteValid),
    .byteChanged       (byteChanged),
    .glyphError        (glyphError),
    .linkActive        (linkActive)
  );

  initial cmosClock = 1'b0;
  always #5 cmosClock = ~cmosClock;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge cmosClock) begin
    if (byteValid === 1'b1)   vldCnt <= vldCnt + 1;
    if (byteChanged === 1'b1) chgCnt <= chgCnt + 1;
    if (glyphError === 1'b1)  errCnt <= errCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; holds the pattern for n cycles and returns at a negedge.
  task automatic drive(input logic [3:0] en, input logic [7:0] d, input int n);
    sevenSegmentEnable = en;
    sevenSegmentData   = d;
    repeat (n) @(negedge cmosClock);
  endtask

  task automatic snap();
    vldBase = vldCnt;
    chgBase = chgCnt;
    errBase = errCnt;
  endtask

  initial begin
    nVec = 0; nBad = 0; vldCnt = 0; chgCnt = 0; errCnt = 0;
    gotValid = 1'b0;
    resetN = 1'b0;
    sevenSegmentEnable = 4'b1111;
    sevenSegmentData   = 8'hFF;
    repeat (3) @(negedge cmosClock);

    check("rst_byteOut", 32'(byteOut), 32'h00);
    check("rst_byteValid", 32'(byteValid), 32'h0);
    check("rst_byteChanged", 32'(byteChanged), 32'h0);
    check("rst_glyphError", 32'(glyphError), 32'h0);
    check("rst_linkActive", 32'(linkActive), 32'h0);
    resetN = 1'b1;
    drive(4'b1111, 8'hFF, 3);

    // First frame A5, with exact latency from digit1 pin change
    snap();
    drive(4'b1110, 8'h92, 10);
    check("d0_linkActive", 32'(linkActive), 32'h1);
    check("d0_noValid", 32'(vldCnt - vldBase), 32'h0);
    sevenSegmentEnable = 4'b1101;
    sevenSegmentData   = 8'h88;
    repeat (6) @(posedge cmosClock);
    #1;
    check("lat_early", 32'(byteValid), 32'h0);
    @(posedge cmosClock);
    #1;
    check("lat_valid", 32'(byteValid), 32'h1);
    check("lat_changed", 32'(byteChanged), 32'h1);
    check("a5_byteOut", 32'(byteOut), 32'hA5);
    @(negedge cmosClock);
    drive(4'b1101, 8'h88, 6);
    check("a5_vldPulses", 32'(vldCnt - vldBase), 32'h1);
    check("a5_chgPulses", 32'(chgCnt - chgBase), 32'h1);
    check("a5_linkActive", 32'(linkActive), 32'h1);

    // Repeated A5: valid without change
    snap();
    drive(4'b1110, 8'h92, 10);
    drive(4'b1101, 8'h88, 10);
    check("rep_vldPulses", 32'(vldCnt - vldBase), 32'h1);
    check("rep_chgPulses", 32'(chgCnt - chgBase), 32'h0);
    check("rep_byteOut", 32'(byteOut), 32'hA5);

    // Low nibble overwrite in HAVE_LO, dp lit on digit0
    snap();
    drive(4'b1110, 8'hF9, 10);
    drive(4'b1111, 8'hFF, 3);
    drive(4'b1110, 8'h30, 10);
    drive(4'b1101, 8'hC6, 10);
    check("ovr_byteOut", 32'(byteOut), 32'hC3);
    check("ovr_vldPulses", 32'(vldCnt - vldBase), 32'h1);
    check("ovr_chgPulses", 32'(chgCnt - chgBase), 32'h1);

    // Digit0 dwell too short to sample
    snap();
    drive(4'b1110, 8'h99, 3);
    drive(4'b1101, 8'h88, 10);
    check("short_vldPulses", 32'(vldCnt - vldBase), 32'h0);
    check("short_byteOut", 32'(byteOut), 32'hC3);

    // Blank digit0 from HUNT
    snap();
    drive(4'b1110, 8'hFF, 10);
    drive(4'b1101, 8'h88, 10);
    check("blank_errPulses", 32'(errCnt - errBase), 32'h1);
    check("blank_vldPulses", 32'(vldCnt - vldBase), 32'h0);
    check("blank_byteOut", 32'(byteOut), 32'hC3);

    // Bad glyph in HAVE_LO drops the held nibble
    snap();
    drive(4'b1110, 8'h92, 10);
    drive(4'b1111, 8'hFF, 3);
    drive(4'b1110, 8'hBF, 10);
    drive(4'b1101, 8'h88, 10);
    check("drop_errPulses", 32'(errCnt - errBase), 32'h1);
    check("drop_vldPulses", 32'(vldCnt - vldBase), 32'h0);
    check("drop_byteOut", 32'(byteOut), 32'hC3);

    // Ignored enables and digit1 from HUNT
    snap();
    drive(4'b1011, 8'h92, 10);
    drive(4'b0111, 8'h88, 10);
    drive(4'b1101, 8'h88, 10);
    drive(4'b1100, 8'h92, 10);
    drive(4'b1101, 8'h88, 10);
    check("ign_vldPulses", 32'(vldCnt - vldBase), 32'h0);
    check("ign_errPulses", 32'(errCnt - errBase), 32'h0);
    check("ign_byteOut", 32'(byteOut), 32'hC3);
    check("ign_linkActive", 32'(linkActive), 32'h1);

    // Link timeout after a frame
    drive(4'b1110, 8'h92, 10);
    sevenSegmentEnable = 4'b1101;
    sevenSegmentData   = 8'h88;
    for (int i = 0; i < 20; i++) begin
      @(posedge cmosClock);
      #1;
      if (byteValid === 1'b1) begin
        gotValid = 1'b1;
        break;
      end
    end
    check("to_frameSeen", 32'(gotValid), 32'h1);
    check("to_byteOut", 32'(byteOut), 32'hA5);
    sevenSegmentEnable = 4'b1111;
    sevenSegmentData   = 8'hFF;
    repeat (63) @(posedge cmosClock);
    #1;
    check("to_stillUp", 32'(linkActive), 32'h1);
    @(posedge cmosClock);
    #1;
    check("to_dropped", 32'(linkActive), 32'h0);
    @(negedge cmosClock);

    // Reset while holding a low nibble
    drive(4'b1110, 8'h86, 10);
    check("hl_linkActive", 32'(linkActive), 32'h1);
    resetN = 1'b0;
    sevenSegmentEnable = 4'b1111;
    sevenSegmentData   = 8'hFF;
    @(posedge cmosClock);
    #1;
    check("mrst_byteOut", 32'(byteOut), 32'h00);
    check("mrst_linkActive", 32'(linkActive), 32'h0);
    check("mrst_pulses", 32'({byteValid, byteChanged, glyphError}), 32'h0);
    @(negedge cmosClock);
    resetN = 1'b1;
    drive(4'b1111, 8'hFF, 3);
    snap();
    drive(4'b1101, 8'h88, 10);
    check("mrst_noValid", 32'(vldCnt - vldBase), 32'h0);
    check("mrst_holdOut", 32'(byteOut), 32'h00);
    drive(4'b1110, 8'h86, 10);
    drive(4'b1101, 8'hA1, 10);
    check("post_byteOut", 32'(byteOut), 32'hDE);
    check("post_vldPulses", 32'(vldCnt - vldBase), 32'h1);
    check("post_chgPulses", 32'(chgCnt - chgBase), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, meaning consecutive stable synchronized cycles an enable pattern must hold before its segment data is sampled.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning cycles without any valid digit capture before linkActive drops.
REQ-003 cmosClock  input  1  single system clock; all state updates on its rising edge.
REQ-004 resetN  input  1  reset, synchronous, active-low.
REQ-005 sevenSegmentEnable  input  4  observed digit enables, active-low, at most one low.
REQ-006 sevenSegmentData  input  8  observed segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-007 byteOut  output  8  last recovered byte, {digit1 nibble, digit0 nibble}.
REQ-008 byteValid  output  1  one-cycle pulse when byteOut is updated from a complete frame.
REQ-009 byteChanged  output  1  one-cycle pulse, coincident with byteValid, when the new byteOut differs from the previous one.
REQ-010 glyphError  output  1  one-cycle pulse when a sampled glyph is not in the hex table.
REQ-011 linkActive  output  1  level; high while valid digit captures arrive within TIMEOUT_CYCLES.

Function
REQ-012 Both input buses SHALL pass through a two-flop synchronizer; all further logic uses synchronized values only.
REQ-013 Digit select: enable pattern 4'b1110 = digit0 (low nibble), 4'b1101 = digit1 (high nibble); 4'b1011, 4'b0111, 4'b1111 and any multi-low pattern SHALL be ignored and clear the settle counter.
REQ-014 Settle counter SHALL clear on every change of the synchronized enable pattern and count while it is unchanged, saturating at SETTLE_CYCLES.
REQ-015 Exactly one sample SHALL be taken per dwell: in the cycle the counter reaches SETTLE_CYCLES on a digit0/digit1 pattern; no resampling until the pattern changes.
REQ-016 Decode SHALL ignore bit 7 (dp) and match bits[6:0] against: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E (hex shown with dp off, bit7=1).
REQ-017 Unmatched glyph SHALL pulse glyphError the cycle after the sample, discard the sample, and return the frame FSM to HUNT.
REQ-018 Frame FSM states: HUNT (no low nibble held), HAVE_LO (low nibble held).
REQ-019 HUNT: valid digit0 sample -> store nibble, go HAVE_LO; digit1 sample -> ignored, stay HUNT.
REQ-020 HAVE_LO: valid digit0 sample -> overwrite stored nibble, stay; valid digit1 sample -> load byteOut, go HUNT.
REQ-021 byteValid (and byteChanged if applicable) SHALL assert in the cycle after the digit1 sample; total latency from digit1 pattern change at the pins to byteValid = 2 + SETTLE_CYCLES + 1 cycles.
REQ-022 byteOut SHALL hold between updates; byteChanged compares against the value held before the update, the first frame after reset compared against 8'h00.
REQ-023 Timeout counter SHALL clear on every valid sample and saturate at TIMEOUT_CYCLES; linkActive = 1 after first valid sample, 0 when counter reaches TIMEOUT_CYCLES.
REQ-024 glyphError samples SHALL NOT clear the timeout counter.

Reset
REQ-025 resetN low at a clock edge SHALL set byteOut=8'h00, byteValid=0, byteChanged=0, glyphError=0, linkActive=0, FSM=HUNT, synchronizers to enable=4'b1111/data=8'hFF, all counters to 0.
REQ-026 Reset asserted mid-frame SHALL discard any held low nibble; no byteValid SHALL follow release until a new digit0 then digit1 sequence completes.

Verification
REQ-027 Drive digit0 enable 1110/data 92 for 10 cycles, then 1101/data 88 for 10 cycles -> byteOut=A5, byteValid and byteChanged single pulse, linkActive=1.
REQ-028 Repeat the A5 frame -> byteValid pulse, byteChanged stays 0, byteOut=A5.
REQ-029 Digit0 data 92 with enable held only 3 synchronized cycles (SETTLE_CYCLES=4) before switching -> no sample, no byteValid after digit1.
REQ-030 Digit0 data FF (blank) then digit1 88 -> glyphError one pulse, FSM HUNT, no byteValid, byteOut unchanged.
REQ-031 Enable 1011 and 0111 with valid glyphs, and digit1 first from HUNT -> no capture, no outputs change.
REQ-032 TIMEOUT_CYCLES=64: valid frame, then enable 1111 for 64 cycles -> linkActive falls at count 64; reset asserted during HAVE_LO -> all outputs 0 next cycle.
